// File: rtl/adc_nch_pkg.sv
// Shared types and helpers for the N-channel ADC AXI-Stream front end.
package adc_nch_pkg;

  localparam int unsigned DROP_CNT_W = 16;
  localparam int unsigned ACC_W_MAX  = 32;

  // Container wide enough for any per-channel accumulator word.
  typedef logic signed [ACC_W_MAX-1:0] acc_word_t;

  function automatic int unsigned acc_w(input int unsigned adc_w,
                                        input int unsigned max_dec_log2);
    return adc_w + max_dec_log2;
  endfunction

  // Keep the MSB, invert the rest, then sign-extend from bit w-1.
  function automatic acc_word_t ob2tc(input logic [31:0] raw, input int unsigned w);
    logic [31:0] flipped;
    flipped = raw ^ ((32'd1 << (w - 1)) - 32'd1);
    return acc_word_t'(flipped << (32 - w)) >>> (32 - w);
  endfunction

endpackage

// File: rtl/adc_nch_boxcar.sv
// One ADC channel: stage-1 conversion register plus boxcar accumulator and 2^k shift.
module adc_nch_boxcar
  import adc_nch_pkg::*;
#(
  parameter int unsigned ADC_W        = 14,
  parameter int unsigned SAMPLE_W     = 16,
  parameter int unsigned MAX_DEC_LOG2 = 8,
  parameter int unsigned KW           = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADC_W-1:0]    raw,
  input  logic [ADC_W-1:0]    pattern,
  input  logic                pattern_sel,
  input  logic                clear,
  input  logic                step,
  input  logic                last,
  input  logic [KW-1:0]       k,
  output logic [SAMPLE_W-1:0] result
);

  localparam int unsigned AccW = acc_w(ADC_W, MAX_DEC_LOG2);

  logic signed [AccW-1:0] conv_d, conv_q, acc_q, sum, avg;

  always_comb begin
    conv_d = AccW'(ob2tc(32'(raw), ADC_W));
    if (pattern_sel) conv_d = AccW'(signed'(pattern));
  end

  // The average of ADC_W-bit samples always fits back into ADC_W bits.
  always_comb begin
    sum    = acc_q + conv_q;
    avg    = sum >>> k;
    result = SAMPLE_W'(signed'(ADC_W'(avg)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_q <= '0;
      acc_q  <= '0;
    end else begin
      conv_q <= conv_d;
      if (clear) begin
        acc_q <= '0;
      end else if (step) begin
        acc_q <= last ? '0 : sum;
      end
    end
  end

endmodule

// File: rtl/axis_red_pitaya_adc_nch.sv
// N-channel ADC to AXI-Stream front end with 2^k boxcar decimation and overrun accounting.
// Optional ramp generator enabled by defining AXIS_ADC_TEST_PATTERN_EN.
module axis_red_pitaya_adc_nch
  import adc_nch_pkg::*;
#(
  parameter int unsigned NCH          = 4,
  parameter int unsigned ADC_W        = 14,
  parameter int unsigned SAMPLE_W     = 16,
  parameter int unsigned MAX_DEC_LOG2 = 8,
  localparam int unsigned KW          = $clog2(MAX_DEC_LOG2 + 1)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [NCH*ADC_W-1:0]    adc_dat_raw,
  input  logic                    cfg_enable,
  input  logic [KW-1:0]           cfg_dec_log2,
  input  logic                    cfg_test_pattern,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tvalid,
  output logic [NCH*SAMPLE_W-1:0] m_axis_tdata,
  output logic                    sts_overrun,
  output logic [DROP_CNT_W-1:0]   sts_drop_cnt
);

  localparam int unsigned   CntW = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;
  localparam logic [KW-1:0] KMax = KW'(MAX_DEC_LOG2);

  logic                    s1_vld_q;
  logic [KW-1:0]           k_q, k_eff;
  logic [CntW-1:0]         cnt_q;
  logic                    dec_change, clear, step, blk_last, res_valid, load, drop;
  logic [NCH*SAMPLE_W-1:0] results;
  logic [ADC_W-1:0]        ramp_q;
  logic                    pattern_sel;

`ifdef AXIS_ADC_TEST_PATTERN_EN
  always_ff @(posedge aclk) begin
    if (areset || !cfg_enable) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_q + ADC_W'(1);
    end
  end
  assign pattern_sel = cfg_test_pattern;
`else
  logic unused_test_pattern;
  assign unused_test_pattern = cfg_test_pattern;
  assign ramp_q              = '0;
  assign pattern_sel         = 1'b0;
`endif

  always_comb begin
    k_eff      = (cfg_dec_log2 > KMax) ? KMax : cfg_dec_log2;
    dec_change = (k_eff != k_q);
    clear      = !cfg_enable || dec_change;
    step       = cfg_enable && s1_vld_q && !dec_change;
    blk_last   = (32'(cnt_q) == ((32'd1 << k_q) - 32'd1));
    res_valid  = step && blk_last;
    load       = res_valid && (!m_axis_tvalid || m_axis_tready);
    drop       = res_valid && m_axis_tvalid && !m_axis_tready;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    adc_nch_boxcar #(
      .ADC_W       (ADC_W),
      .SAMPLE_W    (SAMPLE_W),
      .MAX_DEC_LOG2(MAX_DEC_LOG2),
      .KW          (KW)
    ) u_boxcar (
      .clk        (aclk),
      .rst        (areset),
      .raw        (adc_dat_raw[c*ADC_W +: ADC_W]),
      .pattern    (ramp_q + ADC_W'(c)),
      .pattern_sel(pattern_sel),
      .clear      (clear),
      .step       (step),
      .last       (blk_last),
      .k          (k_q),
      .result     (results[c*SAMPLE_W +: SAMPLE_W])
    );
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_vld_q <= 1'b0;
      k_q      <= '0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= cfg_enable;
      k_q      <= k_eff;
      if (clear) begin
        cnt_q <= '0;
      end else if (step) begin
        cnt_q <= blk_last ? '0 : cnt_q + CntW'(1);
      end
    end
  end

  // A result arriving while the output is stalled is lost; only the counters record it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      sts_overrun   <= 1'b0;
      sts_drop_cnt  <= '0;
    end else begin
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= results;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (drop) begin
        sts_overrun <= 1'b1;
        if (sts_drop_cnt != '1) sts_drop_cnt <= sts_drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

endmodule
